// File: rtl/carddec_pkg.sv
// Shared definitions for the punched-card column decoder: row bit positions,
// EBCDIC character constants and the output sequencer state encoding.
// No logic; imported by punch2ebcdic and card_col_decoder.
package carddec_pkg;

  // Bit positions of each card row inside the 12-bit column word.
  localparam int ROW12 = 11;
  localparam int ROW11 = 10;
  localparam int ROW0  = 9;
  localparam int ROW1  = 8;
  localparam int ROW2  = 7;
  localparam int ROW3  = 6;
  localparam int ROW4  = 5;
  localparam int ROW5  = 4;
  localparam int ROW6  = 3;
  localparam int ROW7  = 2;
  localparam int ROW8  = 1;
  localparam int ROW9  = 0;

  // EBCDIC characters with a fixed role in the decode table.
  localparam logic [7:0] E_SP    = 8'h40;
  localparam logic [7:0] E_SUB   = 8'h3F;
  localparam logic [7:0] E_AMP   = 8'h50;
  localparam logic [7:0] E_MINUS = 8'h60;
  localparam logic [7:0] E_0     = 8'hF0;

  // Output sequencer: S_BIN2 means the low byte of a binary column is pending.
  typedef logic [0:0] carddec_state_t;
  localparam carddec_state_t S_RUN  = 1'b0;
  localparam carddec_state_t S_BIN2 = 1'b1;

endpackage

// File: rtl/punch2ebcdic.sv
// Combinational punch-to-EBCDIC decoder for one 12-row card column.
// Latency: none (pure logic). Backpressure: not applicable.
// Ports: punch[11:0] (bit 11 = row 12 ... bit 0 = row 9), ebcdic[7:0], invalid.
// Build option CARDDEC_VALIDATE_EN: when defined, illegal punch combinations
// decode to SUB (0x3F) with invalid=1; when undefined, invalid is tied to 0
// and illegal combinations fall back to a priority decode.
module punch2ebcdic
  import carddec_pkg::*;
(
  input  logic [11:0] punch,
  output logic [7:0]  ebcdic,
  output logic        invalid
);

  logic       z12, z11, z0;
  logic [9:1] dg;          // dg[k] = digit row k punched
  logic [3:0] lo;          // lowest punched digit
  logic [3:0] lo2;         // lowest punched digit other than 8
  logic [3:0] dsel;        // digit used for the table lookup
  logic       has_d;
  logic       pair8;       // 8 combined with a digit 2..7
  logic       zpair;       // 12-0 or 11-0 with no digits
  logic [7:0] dec;

  always_comb begin
    z12 = punch[ROW12];
    z11 = punch[ROW11];
    z0  = punch[ROW0];
    dg  = {punch[ROW9], punch[ROW8], punch[ROW7], punch[ROW6], punch[ROW5],
           punch[ROW4], punch[ROW3], punch[ROW2], punch[ROW1]};

    // Scan downwards so the smallest punched digit is the one left standing.
    lo  = 4'd0;
    lo2 = 4'd0;
    for (int k = 9; k >= 1; k--) begin
      if (dg[k]) lo = 4'(k);
      if (dg[k] && k != 8) lo2 = 4'(k);
    end

    has_d = |dg;
    pair8 = dg[8] && (lo2 >= 4'd2) && (lo2 <= 4'd7);
    // For a legal column these reduce to the punched digit(s); for illegal
    // ones they implement "8 pairs with the lowest other digit, otherwise
    // the lowest digit wins" (8-1 and 8-9 therefore decode as 1 and 8).
    dsel  = pair8 ? lo2 : lo;
    // 12-0 / 11-0 only form a character without digits; anything else with
    // several zones keeps just the highest one.
    zpair = !has_d && z0 && (z12 ^ z11);

    if (zpair) begin
      dec = z12 ? 8'hC0 : 8'hD0;
    end else if (z12) begin
      dec = !has_d ? E_AMP   : (pair8 ? 8'h48 + 8'(dsel) : 8'hC0 + 8'(dsel));
    end else if (z11) begin
      dec = !has_d ? E_MINUS : (pair8 ? 8'h58 + 8'(dsel) : 8'hD0 + 8'(dsel));
    end else if (z0) begin
      if (!has_d)             dec = E_0;
      else if (pair8)         dec = (dsel == 4'd2) ? 8'hE0 : 8'h68 + 8'(dsel);
      else                    dec = (dsel == 4'd1) ? 8'h61 : 8'hE0 + 8'(dsel);
    end else begin
      dec = !has_d ? E_SP    : (pair8 ? 8'h78 + 8'(dsel) : 8'hF0 + 8'(dsel));
    end
  end

`ifdef CARDDEC_VALIDATE_EN
  logic [3:0] ndig;
  logic [1:0] nzone;

  always_comb begin
    ndig = 4'd0;
    for (int k = 1; k <= 9; k++) ndig = ndig + 4'(dg[k]);
    nzone   = {1'b0, z12} + {1'b0, z11} + {1'b0, z0};
    invalid = !(((ndig <= 4'd1) || ((ndig == 4'd2) && pair8)) &&
                ((nzone <= 2'd1) || zpair));
    ebcdic  = invalid ? E_SUB : dec;
  end
`else
  assign invalid = 1'b0;
  assign ebcdic  = dec;
`endif

endmodule

// File: rtl/card_col_decoder.sv
// Streaming card column decoder: one 12-row column in, one EBCDIC byte or two
// raw 6-bit bytes (column-binary mode) out, with column position and error flag.
// Latency: 1 cycle (registered output). Backpressure: o_valid && !i_ready holds
// all outputs and drops o_ready; binary columns also block input for a cycle.
// Ports: i_clk, i_rst_n (async, active-low), i_clr (sync card restart),
// i_mode (sampled at column 1), i_col/i_valid/o_ready input handshake,
// o_data/o_valid/i_ready output handshake, o_col, o_last, o_err sidebands.
// Build option CARDDEC_VALIDATE_EN selects punch validation (see punch2ebcdic).
module card_col_decoder
  import carddec_pkg::*;
#(
  parameter int COLS = 80,
  parameter int CNTW = $clog2(COLS + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clr,
  input  logic            i_mode,
  input  logic [11:0]     i_col,
  input  logic            i_valid,
  output logic            o_ready,
  output logic [7:0]      o_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [CNTW-1:0] o_col,
  output logic            o_last,
  output logic            o_err
);

  carddec_state_t  state;
  logic [CNTW-1:0] cnt;        // 1-based number of the next column to accept
  logic            mode_q;
  logic [7:0]      lo_q;       // pending low byte of a binary column
  logic            lo_last_q;

  logic [7:0]      dec;
  logic            dec_inv;
  logic            take, accept, first, wrap, mode_eff;

  punch2ebcdic u_dec (
    .punch   (i_col),
    .ebcdic  (dec),
    .invalid (dec_inv)
  );

  assign take    = o_valid && i_ready;
  assign o_ready = !i_clr && (state == S_RUN) && (!o_valid || i_ready);
  assign accept  = i_valid && o_ready;
  assign first   = (cnt == CNTW'(1));
  assign wrap    = (cnt == CNTW'(COLS));
  // Column 1 uses the live mode bit; the rest of the card uses the latched one.
  assign mode_eff = first ? i_mode : mode_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_RUN;
      cnt       <= CNTW'(1);
      mode_q    <= 1'b0;
      lo_q      <= 8'h00;
      lo_last_q <= 1'b0;
      o_data    <= 8'h00;
      o_valid   <= 1'b0;
      o_col     <= '0;
      o_last    <= 1'b0;
      o_err     <= 1'b0;
    end else if (i_clr) begin
      state   <= S_RUN;
      cnt     <= CNTW'(1);
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_col   <= cnt;
      cnt     <= wrap ? CNTW'(1) : cnt + CNTW'(1);
      if (first) mode_q <= i_mode;
      if (mode_eff) begin
        o_data    <= {2'b00, i_col[11:6]};
        o_err     <= 1'b0;
        o_last    <= 1'b0;         // last flag travels with the low byte
        lo_q      <= {2'b00, i_col[5:0]};
        lo_last_q <= wrap;
        state     <= S_BIN2;
      end else begin
        o_data <= dec;
        o_err  <= dec_inv;
        o_last <= wrap;
      end
    end else if (state == S_BIN2 && take) begin
      // High byte leaves this edge; low byte replaces it, same o_col.
      o_data <= lo_q;
      o_last <= lo_last_q;
      o_err  <= 1'b0;
      state  <= S_RUN;
    end else if (take) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_card_col_decoder.sv
module tb_card_col_decoder;

  localparam int COLS = 80;
  localparam int CNTW = 7;

  logic            i_clk   = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_clr   = 1'b0;
  logic            i_mode  = 1'b0;
  logic [11:0]     i_col   = 12'h000;
  logic            i_valid = 1'b0;
  logic            i_ready = 1'b1;
  logic            o_ready, o_valid, o_last, o_err;
  logic [7:0]      o_data;
  logic [CNTW-1:0] o_col;

  typedef struct packed {
    logic [7:0]      d;
    logic [CNTW-1:0] c;
    logic            l;
    logic            e;
  } exp_t;

  exp_t sb[$];
  int   errors  = 0;
  int   checks  = 0;
  int   exp_col = 1;

  logic [11:0] tp[12];
  logic [7:0]  te[12];

  card_col_decoder #(.COLS(COLS)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr),
    .i_mode  (i_mode),
    .i_col   (i_col),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_col   (o_col),
    .o_last  (o_last),
    .o_err   (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every output transfer is popped and compared.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL spurious_byte: observed data=%0h col=%0d expected no byte", o_data, o_col);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", 32'(o_data), 32'(e.d));
        chk("col",  32'(o_col),  32'(e.c));
        chk("last", 32'(o_last), 32'(e.l));
        chk("err",  32'(o_err),  32'(e.e));
      end
    end
  end

  // Present one column and hold it until the DUT accepts it (bounded wait).
  task automatic send(input logic [11:0] col, input logic mode);
    int n;
    n = 0;
    i_col   = col;
    i_mode  = mode;
    i_valid = 1'b1;
    @(negedge i_clk);
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed o_ready=0 for %0d cycles expected 1", n);
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic next_col();
    exp_col = (exp_col == COLS) ? 1 : exp_col + 1;
  endtask

  task automatic ebc(input logic [11:0] col, input logic mode,
                     input logic [7:0] data, input logic err);
    sb.push_back(exp_t'{data, CNTW'(exp_col), exp_col == COLS, err});
    send(col, mode);
    next_col();
  endtask

  task automatic bin(input logic [11:0] col, input logic mode);
    logic [11:0] v;
    v = col;
    sb.push_back(exp_t'{{2'b00, v[11:6]}, CNTW'(exp_col), 1'b0, 1'b0});
    sb.push_back(exp_t'{{2'b00, v[5:0]},  CNTW'(exp_col), exp_col == COLS, 1'b0});
    send(col, mode);
    next_col();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout: observed %0d bytes outstanding expected 0", sb.size());
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    tp[0]  = 12'h000; te[0]  = 8'h40;
    tp[1]  = 12'h100; te[1]  = 8'hF1;
    tp[2]  = 12'h900; te[2]  = 8'hC1;
    tp[3]  = 12'h280; te[3]  = 8'hE2;
    tp[4]  = 12'h042; te[4]  = 8'h7B;
    tp[5]  = 12'h842; te[5]  = 8'h4B;
    tp[6]  = 12'h400; te[6]  = 8'h60;
    tp[7]  = 12'h201; te[7]  = 8'hE9;
    tp[8]  = 12'h600; te[8]  = 8'hD0;
    tp[9]  = 12'h300; te[9]  = 8'h61;
    tp[10] = 12'h282; te[10] = 8'hE0;
    tp[11] = 12'h442; te[11] = 8'h5B;

    // Reset state.
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_col",   32'(o_col),   32'd0);
    chk("rst_data",  32'(o_data),  32'h00);
    chk("rst_last",  32'(o_last),  32'd0);
    chk("rst_err",   32'(o_err),   32'd0);
    @(posedge i_clk);
    #1;

    // EBCDIC decode, columns 1..6.
    for (int i = 0; i < 6; i++) ebc(tp[i], 1'b0, te[i], 1'b0);

    // Illegal punches, columns 7..8.
`ifdef CARDDEC_VALIDATE_EN
    ebc(12'h180, 1'b0, 8'h3F, 1'b1);
    ebc(12'hC00, 1'b0, 8'h3F, 1'b1);
`else
    ebc(12'h180, 1'b0, 8'hF1, 1'b0);
    ebc(12'hC00, 1'b0, 8'h50, 1'b0);
`endif
    drain();

    // Backpressure: column 9 held for 3 cycles while column 10 waits.
    i_ready = 1'b0;
    ebc(12'h900, 1'b0, 8'hC1, 1'b0);
    i_col   = 12'h100;
    i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_data",  32'(o_data),  32'hC1);
      chk("bp_col",   32'(o_col),   32'd9);
      chk("bp_ready", 32'(o_ready), 32'd0);
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    ebc(12'h100, 1'b0, 8'hF1, 1'b0);

    // Rest of card 1 (o_last expected only on column 80), then card 2 to 36.
    while (exp_col != 1) ebc(tp[exp_col % 12], 1'b0, te[exp_col % 12], 1'b0);
    while (exp_col != 37) ebc(tp[exp_col % 12], 1'b0, te[exp_col % 12], 1'b0);

    // Card restart presented together with column 37: column is refused.
    i_clr   = 1'b1;
    i_col   = 12'h100;
    i_valid = 1'b1;
    @(negedge i_clk);
    chk("clr_ready", 32'(o_ready), 32'd0);
    @(posedge i_clk);
    #1;
    i_clr   = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("clr_valid", 32'(o_valid), 32'd0);
    @(posedge i_clk);
    #1;
    exp_col = 1;

    // Column-binary card; mode toggles after column 1 must be ignored.
    bin(12'hABC, 1'b1);
    @(negedge i_clk);
    chk("bin_ready", 32'(o_ready), 32'd0);
    @(posedge i_clk);
    #1;
    for (int k = 2; k <= COLS; k++) bin(12'(k * 293 + 5), 1'(k));

    // Next card in EBCDIC, mode toggle after column 1 ignored again.
    ebc(12'h100, 1'b0, 8'hF1, 1'b0);
    ebc(12'h280, 1'b1, 8'hE2, 1'b0);
    ebc(12'h900, 1'b0, 8'hC1, 1'b0);
    drain();
    chk("idle_valid", 32'(o_valid), 32'd0);

    // Asynchronous reset mid-card.
    i_rst_n = 1'b0;
    #2;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_col",   32'(o_col),   32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    exp_col = 1;
    ebc(12'h842, 1'b0, 8'h4B, 1'b0);
    drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
